// File: rtl/z80_bus_ctrl.sv
// -----------------------------------------------------------------------------
// z80_bus_ctrl
//
// Bus controller sitting behind the Z80 core wrapper. It decodes the CPU
// address and the registered strobes, and it steers ROM, RAM, input ports or
// the interrupt vector onto DATA_IN. It also produces the RAM write strobe and
// the output-port latches, and it owns the vblank interrupt request and its
// acknowledge.
//
// Optional feature: define WATCHDOG_EN to build the watchdog down-counter.
// When WATCHDOG_EN is not defined, wdt_reset_n is tied high and writes to
// port 0x02 have no effect.
//
// Ports
//   CLK          in   1   system clock
//   nRESET       in   1   synchronous active-low reset
//   ADDRESS      in   16  CPU address
//   DATA_OUT     in   8   CPU write data
//   nMREQ,nIORQ  in   1   CPU strobes, active low
//   nRD,nWR      in   1   CPU strobes, active low
//   DATA_IN      out  8   read data to CPU (combinational from registered select)
//   nINT         out  1   interrupt request, registered, active low
//   vblank       in   1   asynchronous vblank from the video timing
//   rom_q        in   8   synchronous ROM data
//   ram_q        in   8   synchronous RAM data
//   ram_we       out  1   RAM write strobe, one-CLK pulse
//   in_p1        in   8   player inputs (read port 0x00)
//   in_dsw       in   8   DIP switches (read port 0x01)
//   pal_sel      out  3   palette select (write port 0x00 bits [2:0])
//   flip         out  1   screen flip (write port 0x00 bit 3)
//   wdt_reset_n  out  1   watchdog reset request, active low
// -----------------------------------------------------------------------------
module z80_bus_ctrl #(
  parameter int unsigned ROM_AW     = 14,
  parameter logic [15:0] RAM_BASE   = 16'h8000,
  parameter int unsigned RAM_AW     = 11,
  parameter logic [7:0]  INT_VECTOR = 8'hFF,
  parameter logic        IRQ_EN_RST = 1'b1,
  parameter logic [23:0] WDT_CYCLES = 24'd3000000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] ADDRESS,
  input  logic [7:0]  DATA_OUT,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic [7:0]  DATA_IN,
  output logic        nINT,
  input  logic        vblank,
  input  logic [7:0]  rom_q,
  input  logic [7:0]  ram_q,
  output logic        ram_we,
  input  logic [7:0]  in_p1,
  input  logic [7:0]  in_dsw,
  output logic [2:0]  pal_sel,
  output logic        flip,
  output logic        wdt_reset_n
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ROM,
    SEL_RAM,
    SEL_P1,
    SEL_DSW,
    SEL_VEC
  } sel_t;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic       bus_conflict;
  logic       mem_rd, mem_wr, io_rd, io_wr, int_ack;
  logic       rom_hit, ram_hit;
  logic [7:0] io_port;

  // Memory and I/O requested together is treated as no access at all.
  assign bus_conflict = !nMREQ && !nIORQ;
  assign mem_rd  = !nMREQ && !nRD && !bus_conflict;
  assign mem_wr  = !nMREQ && !nWR && !bus_conflict;
  assign io_rd   = !nIORQ && !nRD && !bus_conflict;
  assign io_wr   = !nIORQ && !nWR && !bus_conflict;
  assign int_ack = !nIORQ && nRD && nWR && nMREQ;

  // ROM takes priority so that a misconfigured overlap never writes RAM
  // through the ROM window.
  assign rom_hit = (ADDRESS[15:ROM_AW] == '0);
  assign ram_hit = (ADDRESS[15:RAM_AW] == RAM_BASE[15:RAM_AW]) && !rom_hit;
  assign io_port = ADDRESS[7:0];

  // ---------------------------------------------------------------------------
  // Read select: registered so it lines up with the synchronous ROM/RAM data.
  // ---------------------------------------------------------------------------
  sel_t sel_d, sel_q;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sel_d = SEL_NONE;
    if (mem_rd) begin
      if (rom_hit)      sel_d = SEL_ROM;
      else if (ram_hit) sel_d = SEL_RAM;
    end else if (io_rd) begin
      if (io_port == 8'h00)      sel_d = SEL_P1;
      else if (io_port == 8'h01) sel_d = SEL_DSW;
    end else if (int_ack) begin
      sel_d = SEL_VEC;
    end
  end

  always_comb begin
    DATA_IN = 8'hFF;
    case (sel_q)
      SEL_ROM: DATA_IN = rom_q;
      SEL_RAM: DATA_IN = ram_q;
      SEL_P1:  DATA_IN = in_p1;
      SEL_DSW: DATA_IN = in_dsw;
      SEL_VEC: DATA_IN = INT_VECTOR;
      default: DATA_IN = 8'hFF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Interrupt request
  // ---------------------------------------------------------------------------
  logic [2:0] vb_sync;     // [0],[1] synchroniser, [2] edge-detect history
  logic       vb_rise;
  logic       irq_en, irq_pend, irq_pend_d;
  logic       int_ack_q, mem_wr_q;
  logic       irq_dis_wr;

  assign vb_rise    = vb_sync[1] && !vb_sync[2];
  assign irq_dis_wr = io_wr && (io_port == 8'h01) && !DATA_OUT[0];

  // Later assignments win: disable beats a new edge, a new edge beats ack.
  always_comb begin
    irq_pend_d = irq_pend;
    if (int_ack && !int_ack_q) irq_pend_d = 1'b0;
    if (vb_rise && irq_en)     irq_pend_d = 1'b1;
    if (irq_dis_wr)            irq_pend_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      sel_q     <= SEL_NONE;
      mem_wr_q  <= 1'b0;
      int_ack_q <= 1'b0;
      ram_we    <= 1'b0;
      pal_sel   <= 3'd0;
      flip      <= 1'b0;
      irq_en    <= IRQ_EN_RST;
      irq_pend  <= 1'b0;
      nINT      <= 1'b1;
      vb_sync   <= 3'b000;
    end else begin
      sel_q     <= sel_d;
      mem_wr_q  <= mem_wr;
      int_ack_q <= int_ack;
      // Only the first cycle of a write strobe fires the pulse.
      ram_we    <= mem_wr && !mem_wr_q && ram_hit;
      if (io_wr && (io_port == 8'h00)) begin
        pal_sel <= DATA_OUT[2:0];
        flip    <= DATA_OUT[3];
      end
      if (io_wr && (io_port == 8'h01)) irq_en <= DATA_OUT[0];
      vb_sync   <= {vb_sync[1:0], vblank};
      irq_pend  <= irq_pend_d;
      // Driven from the next-state value so nINT follows the edge in one CLK.
      nINT      <= !irq_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef WATCHDOG_EN
  logic        wdt_kick;
  logic [23:0] wdt_cnt;
  logic        wdt_active;
  logic [3:0]  wdt_win;
  logic        unused_bits;

  assign wdt_kick    = io_wr && (io_port == 8'h02);
  assign wdt_reset_n = !wdt_active;
  assign unused_bits = &{1'b0, DATA_OUT[7:4], ADDRESS};

  // The 16-CLK reset window runs to completion; kicks are ignored inside it.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      wdt_cnt    <= WDT_CYCLES;
      wdt_active <= 1'b0;
      wdt_win    <= 4'd0;
    end else if (wdt_active) begin
      if (wdt_win == 4'd0) begin
        wdt_active <= 1'b0;
        wdt_cnt    <= WDT_CYCLES;
      end else begin
        wdt_win <= wdt_win - 4'd1;
      end
    end else if (wdt_kick) begin
      wdt_cnt <= WDT_CYCLES;
    end else if (wdt_cnt <= 24'd1) begin
      wdt_cnt    <= 24'd0;
      wdt_active <= 1'b1;
      wdt_win    <= 4'd15;
    end else begin
      wdt_cnt <= wdt_cnt - 24'd1;
    end
  end
`else
  logic unused_bits;

  assign wdt_reset_n = 1'b1;
  assign unused_bits = &{1'b0, DATA_OUT[7:4], ADDRESS, WDT_CYCLES};
`endif

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_ctrl
//
// Scoreboard bench for z80_bus_ctrl. Stimulus tasks push the expected read
// data, write-strobe outcome and port-latch state into queues; a monitor that
// watches the bus strobes pops and compares one CLK later. Expected values
// come from address-range arithmetic, not from the design's structure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_z80_bus_ctrl;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [15:0] ADDRESS;
  logic [7:0]  DATA_OUT;
  logic        nMREQ, nIORQ, nRD, nWR;
  logic [7:0]  DATA_IN;
  logic        nINT;
  logic        vblank;
  logic [7:0]  rom_q, ram_q;
  logic        ram_we;
  logic [7:0]  in_p1, in_dsw;
  logic [2:0]  pal_sel;
  logic        flip;
  logic        wdt_reset_n;

  always #5 CLK = ~CLK;

  z80_bus_ctrl #(.WDT_CYCLES(24'd100)) dut (
    .CLK(CLK), .nRESET(nRESET), .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .DATA_IN(DATA_IN), .nINT(nINT), .vblank(vblank),
    .rom_q(rom_q), .ram_q(ram_q), .ram_we(ram_we),
    .in_p1(in_p1), .in_dsw(in_dsw), .pal_sel(pal_sel), .flip(flip),
    .wdt_reset_n(wdt_reset_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory contents and reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_val(input logic [15:0] a);
    return ~a[7:0] ^ {5'b00000, a[10:8]};
  endfunction

  function automatic bit in_ram(input logic [15:0] a);
    return (a >= 16'h8000) && (a < 16'h8800);
  endfunction

  function automatic logic [7:0] exp_mem(input logic [15:0] a);
    if (a < 16'h4000) return rom_val(a);
    if (in_ram(a))    return ram_val(a);
    return 8'hFF;
  endfunction

  // Synchronous ROM/RAM: data for the address presented appears after the edge.
  always @(posedge CLK) begin
    rom_q <= rom_val(ADDRESS);
    ram_q <= ram_val(ADDRESS);
  end

  logic [7:0] rd_q[$];
  bit         we_q[$];
  logic [3:0] cfg_q[$];
  logic [2:0] pal_m = 3'd0;
  logic       flip_m = 1'b0;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic       mon_rd = 1'b0, mon_mw = 1'b0, mon_iow = 1'b0;
  logic [7:0] mon_exp_d;
  bit         mon_exp_w;
  logic [3:0] mon_exp_c;

  always @(posedge CLK) begin
    mon_rd  <= nRESET && !(!nMREQ && !nIORQ) &&
               ((!nMREQ && !nRD) || (!nIORQ && !nRD) || (!nIORQ && nRD && nWR && nMREQ));
    mon_mw  <= nRESET && !nMREQ && nIORQ && !nWR;
    mon_iow <= nRESET && !nIORQ && nMREQ && !nWR;
  end

  always @(negedge CLK) begin
    if (mon_rd) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL data_in_unexpected: got 0x%0h, expected no read", DATA_IN);
      end else begin
        mon_exp_d = rd_q.pop_front();
        check("data_in", DATA_IN, mon_exp_d);
      end
    end
    if (mon_mw) begin
      if (we_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ram_we_unexpected: got %0b, expected no write", ram_we);
      end else begin
        mon_exp_w = we_q.pop_front();
        check("ram_we", ram_we, mon_exp_w);
      end
    end else if (ram_we) begin
      n_checks++; n_fail++;
      $display("FAIL ram_we_spurious: got 1, expected 0");
    end
    if (mon_iow) begin
      if (cfg_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL io_write_unexpected: got %0h, expected none", {flip, pal_sel});
      end else begin
        mon_exp_c = cfg_q.pop_front();
        check("flip_pal", {flip, pal_sel}, mon_exp_c);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic m, input logic i, input logic r, input logic w,
                       input logic [15:0] a, input logic [7:0] d, input int cyc);
    ADDRESS = a; DATA_OUT = d;
    nMREQ = !m; nIORQ = !i; nRD = !r; nWR = !w;
    repeat (cyc) @(negedge CLK);
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic mem_read(input logic [15:0] a);
    rd_q.push_back(exp_mem(a));
    drive(1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, 1);
  endtask

  task automatic mem_write(input logic [15:0] a, input int cyc);
    for (int k = 0; k < cyc; k++) we_q.push_back((k == 0) && in_ram(a));
    drive(1'b1, 1'b0, 1'b0, 1'b1, a, 8'($urandom), cyc);
  endtask

  task automatic io_read(input logic [15:0] a);
    in_p1  = 8'($urandom);
    in_dsw = 8'($urandom);
    if (a[7:0] == 8'h00)      rd_q.push_back(in_p1);
    else if (a[7:0] == 8'h01) rd_q.push_back(in_dsw);
    else                      rd_q.push_back(8'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00, 1);
    @(negedge CLK);  // hold the port inputs until the compare has happened
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    if (a[7:0] == 8'h00) begin
      pal_m  = d[2:0];
      flip_m = d[3];
    end
    cfg_q.push_back({flip_m, pal_m});
    drive(1'b0, 1'b1, 1'b0, 1'b1, a, d, 1);
  endtask

  task automatic int_ack_cycle();
    rd_q.push_back(8'hFF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, ADDRESS, 8'h00, 1);
  endtask

  task automatic wait_nint(input logic val, input int max_cyc, output int took);
    took = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge CLK);
      if (nINT === val) begin
        took = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int          took;
  int          lowc;
  bit          saw_low;
  logic [15:0] ra;
  int          kind;

  initial begin
    nRESET = 1'b0; ADDRESS = 16'h0000; DATA_OUT = 8'h00;
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    vblank = 1'b0; in_p1 = 8'h00; in_dsw = 8'h00;

    // Reset values
    repeat (5) @(negedge CLK);
    check("reset_nint", nINT, 1'b1);
    check("reset_ram_we", ram_we, 1'b0);
    check("reset_pal_sel", pal_sel, 3'd0);
    check("reset_flip", flip, 1'b0);
    check("reset_wdt_reset_n", wdt_reset_n, 1'b1);
    nRESET = 1'b1;
    idle(2);

    // Directed reads, writes and port accesses
    mem_read(16'h1234);  idle(1);
    mem_read(16'h8010);  idle(1);
    mem_read(16'h4000);  idle(1);
    mem_read(16'h87FF);  idle(1);
    mem_read(16'h8800);  idle(1);
    mem_write(16'h87FF, 1); idle(1);
    mem_write(16'h0100, 1); idle(1);
    mem_write(16'h8000, 2); idle(1);
    io_write(16'h0000, 8'h0D); idle(1);
    check("pal_sel_after_port0", pal_sel, 3'd5);
    check("flip_after_port0", flip, 1'b1);
    io_write(16'h0003, 8'hF2); idle(1);
    io_write(16'h0100, 8'h02); idle(1);   // port 0x00 with high byte set
    io_read(16'h0000); idle(1);
    io_read(16'h0001); idle(1);
    io_read(16'h0002); idle(1);
    io_read(16'h7F01); idle(1);

    // Randomised traffic
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 2))
        0:       ra = 16'($urandom_range(0, 16'h3FFF));
        1:       ra = 16'h8000 + 16'($urandom_range(0, 16'h07FF));
        default: ra = 16'($urandom);
      endcase
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: mem_read(ra);
        1: mem_write(ra, int'($urandom_range(1, 2)));
        2: begin
          case ($urandom_range(0, 3))
            0:       ra[7:0] = 8'h00;
            1:       ra[7:0] = 8'h01;
            2:       ra[7:0] = 8'h02;
            default: ra[7:0] = 8'($urandom);
          endcase
          io_read(ra);
        end
        default: begin
          case ($urandom_range(0, 3))
            0:       ra[7:0] = 8'h00;
            1:       ra[7:0] = 8'h02;
            2:       ra[7:0] = 8'h03;
            default: ra[7:0] = 8'($urandom);
          endcase
          if (ra[7:0] == 8'h01) ra[7:0] = 8'h80;
          io_write(ra, 8'($urandom));
        end
      endcase
      idle(1 + int'($urandom_range(0, 1)));
    end

    // Interrupt: assert, hold, acknowledge
    idle(2);
    vblank = 1'b1;
    wait_nint(1'b0, 6, took);
    check("nint_assert_within_3", (took >= 1 && took <= 3), 1'b1);
    idle(4);
    check("nint_level_held", nINT, 1'b0);
    vblank = 1'b0;
    int_ack_cycle();
    check("nint_after_ack", nINT, 1'b1);
    idle(4);
    check("nint_no_spurious", nINT, 1'b1);

    // Acknowledge landing on the same CLK as a new edge: set wins
    vblank = 1'b1;
    wait_nint(1'b0, 6, took);
    check("nint_reassert", (took >= 1 && took <= 3), 1'b1);
    vblank = 1'b0;
    idle(4);
    vblank = 1'b1;
    idle(2);
    int_ack_cycle();
    check("nint_ack_vs_edge", nINT, 1'b0);
    idle(3);
    check("nint_still_low", nINT, 1'b0);
    vblank = 1'b0;
    idle(3);
    int_ack_cycle();
    check("nint_ack_clears", nINT, 1'b1);

    // Disable while pending, then edges while disabled
    idle(4);
    vblank = 1'b1;
    wait_nint(1'b0, 6, took);
    check("nint_pend_before_disable", (took >= 1 && took <= 3), 1'b1);
    io_write(16'h0001, 8'h00);
    check("nint_after_disable", nINT, 1'b1);
    for (int e = 0; e < 2; e++) begin
      vblank = 1'b0; idle(3);
      vblank = 1'b1; idle(6);
      check("nint_disabled_edge", nINT, 1'b1);
    end
    vblank = 1'b0;
    io_write(16'h0001, 8'h01);
    idle(4);
    check("nint_reenable_no_stale", nINT, 1'b1);

`ifdef WATCHDOG_EN
    // Timeout with no kicks
    nRESET = 1'b0; idle(2); pal_m = 3'd0; flip_m = 1'b0; nRESET = 1'b1;
    took = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      if (!wdt_reset_n) begin
        took = k;
        break;
      end
    end
    check("wdt_timeout_cycles", took, 100);
    lowc = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (wdt_reset_n) break;
      lowc++;
    end
    check("wdt_low_width", lowc, 16);

    // A kick inside the window does not shorten it
    nRESET = 1'b0; idle(2); nRESET = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      if (!wdt_reset_n) break;
    end
    idle(4);
    io_write(16'h0002, 8'h00);
    lowc = 6;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (wdt_reset_n) break;
      lowc++;
    end
    check("wdt_width_with_kick", lowc, 16);

    // Regular kicks keep it quiet
    nRESET = 1'b0; idle(2); nRESET = 1'b1;
    saw_low = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 49; k++) begin
        @(negedge CLK);
        if (!wdt_reset_n) saw_low = 1'b1;
      end
      io_write(16'h0002, 8'h00);
      if (!wdt_reset_n) saw_low = 1'b1;
    end
    check("wdt_kicked_never_low", saw_low, 1'b0);
`else
    saw_low = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (!wdt_reset_n) saw_low = 1'b1;
    end
    check("wdt_tied_high", saw_low, 1'b0);
`endif

    idle(3);
    check("rd_queue_drained", rd_q.size(), 0);
    check("we_queue_drained", we_q.size(), 0);
    check("cfg_queue_drained", cfg_q.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
